// File: rtl/img2col_map_ctrl.sv
// Mapping controller for the img2col front end: pre-fills KSIZE-1 rows into NUM_PU units, then streams one row per round.
// Optional abort input enabled by defining IMG2COL_MAP_ABORT_EN.
module img2col_map_ctrl #(
    parameter int NUM_PU   = 28,
    parameter int KSIZE    = 5,
    parameter int IMG_ROWS = 32,
    parameter int CW       = 6
) (
    input  logic              clk,
    input  logic              nrst,
`ifdef IMG2COL_MAP_ABORT_EN
    input  logic              abort,
`endif
    input  logic              start,
    input  logic              stall,
    input  logic [NUM_PU-1:0] pu_ready,
    output logic [CW-1:0]     cur_pu_add,
    output logic [CW-1:0]     cur_pu_no,
    output logic [CW-1:0]     cur_row_no,
    output logic [CW-1:0]     cur_round,
    output logic              busy,
    output logic              act,
    output logic              map_finish
);

    localparam int NUM_ROUNDS = IMG_ROWS - KSIZE + 1;
    localparam int MAX_A      = (NUM_PU > KSIZE) ? NUM_PU : KSIZE;
    localparam int MAX_V      = (MAX_A > IMG_ROWS) ? MAX_A : IMG_ROWS;

    localparam logic [CW-1:0] ONE        = CW'(1);
    localparam logic [CW-1:0] ADD_LAST   = CW'(KSIZE - 1);
    localparam logic [CW-1:0] PU_LAST    = CW'(NUM_PU - 1);
    localparam logic [CW-1:0] ROW_WORK   = CW'(KSIZE - 1);
    localparam logic [CW-1:0] ROUND_LAST = CW'(NUM_ROUNDS - 1);

    if ((2 ** CW) <= MAX_V) begin : g_cw_check
        $error("img2col_map_ctrl: CW too small for NUM_PU/KSIZE/IMG_ROWS");
    end

    typedef enum logic [1:0] {
        S_IDLE,
        S_BUFFER,
        S_WORK,
        S_FINISH
    } state_t;

    state_t state;
    logic   ready_sel;
    logic   abort_req;

`ifdef IMG2COL_MAP_ABORT_EN
    assign abort_req = abort;
`else
    assign abort_req = 1'b0;
`endif

    always_comb begin
        ready_sel = 1'b0;
        for (int i = 0; i < NUM_PU; i++) begin
            if (cur_pu_no == CW'(i)) ready_sel = pu_ready[i];
        end
    end

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            state <= S_IDLE;
            {cur_pu_add, cur_pu_no, cur_row_no, cur_round} <= '0;
            busy       <= 1'b0;
            act        <= 1'b0;
            map_finish <= 1'b0;
        end else begin
            act        <= 1'b0;
            map_finish <= 1'b0;
            case (state)
                S_IDLE: begin
                    {cur_pu_add, cur_pu_no, cur_row_no, cur_round} <= '0;
                    if (start) begin
                        state <= (KSIZE > 1) ? S_BUFFER : S_WORK;
                        busy  <= 1'b1;
                    end
                end
                S_BUFFER: begin
                    if (abort_req) begin
                        state <= S_IDLE;
                        busy  <= 1'b0;
                        {cur_pu_add, cur_pu_no, cur_row_no, cur_round} <= '0;
                    end else if (!stall) begin
                        if (cur_pu_add != ADD_LAST) begin
                            cur_pu_add <= cur_pu_add + ONE;
                        end else begin
                            cur_pu_add <= '0;
                            if (cur_pu_no != PU_LAST) begin
                                cur_pu_no <= cur_pu_no + ONE;
                            end else begin
                                cur_pu_no  <= '0;
                                cur_row_no <= cur_row_no + ONE;
                                if ((cur_row_no + ONE) == ROW_WORK) begin
                                    state     <= S_WORK;
                                    cur_round <= '0;
                                end
                            end
                        end
                    end
                end
                S_WORK: begin
                    if (abort_req) begin
                        state <= S_IDLE;
                        busy  <= 1'b0;
                        {cur_pu_add, cur_pu_no, cur_row_no, cur_round} <= '0;
                    end else if (!stall) begin
                        // The last word of a PU is held until that PU reports acceptance.
                        if (cur_pu_add != ADD_LAST) begin
                            cur_pu_add <= cur_pu_add + ONE;
                        end else if (ready_sel) begin
                            cur_pu_add <= '0;
                            if (cur_pu_no != PU_LAST) begin
                                cur_pu_no <= cur_pu_no + ONE;
                            end else begin
                                cur_pu_no <= '0;
                                act       <= 1'b1;
                                if (cur_round != ROUND_LAST) begin
                                    cur_round  <= cur_round + ONE;
                                    cur_row_no <= cur_row_no + ONE;
                                end else begin
                                    state <= S_FINISH;
                                    busy  <= 1'b0;
                                end
                            end
                        end
                    end
                end
                S_FINISH: begin
                    // Pulse lands one cycle after the final act, with counters already cleared.
                    map_finish <= 1'b1;
                    state      <= S_IDLE;
                    {cur_pu_add, cur_pu_no, cur_row_no, cur_round} <= '0;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_img2col_map_ctrl.sv
// Scoreboard bench for img2col_map_ctrl with NUM_PU=4, KSIZE=3, IMG_ROWS=6 (12-cycle rounds, 24-cycle pre-fill).
module tb_img2col_map_ctrl;

    localparam int NPU = 4;
    localparam int CWT = 4;

    logic           clk;
    logic           nrst;
    logic           start;
    logic           stall;
    logic [NPU-1:0] pu_ready;
`ifdef IMG2COL_MAP_ABORT_EN
    logic           abort;
`endif
    logic [CWT-1:0] cur_pu_add, cur_pu_no, cur_row_no, cur_round;
    logic           busy, act, map_finish;

    img2col_map_ctrl #(.NUM_PU(NPU), .KSIZE(3), .IMG_ROWS(6), .CW(CWT)) dut (
        .clk(clk),
        .nrst(nrst),
`ifdef IMG2COL_MAP_ABORT_EN
        .abort(abort),
`endif
        .start(start),
        .stall(stall),
        .pu_ready(pu_ready),
        .cur_pu_add(cur_pu_add),
        .cur_pu_no(cur_pu_no),
        .cur_row_no(cur_row_no),
        .cur_round(cur_round),
        .busy(busy),
        .act(act),
        .map_finish(map_finish)
    );

    typedef struct {
        int cyc;
        int busy;
        int add;
        int pu;
        int row;
        int rnd;
    } probe_t;

    typedef struct {
        int kind;
        int cyc;
        int rnd;
        int row;
    } ev_t;

    probe_t probe_q[$];
    ev_t    ev_q[$];
    int     cyc = 0;
    int     vectors = 0;
    int     miscompares = 0;
    ev_t    mon_e;
    probe_t mon_p;

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input int got, input int exp);
        vectors++;
        if (got != exp) begin
            miscompares++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", nm, got, exp, cyc);
        end
    endtask

    task automatic push_probe(input int c, input int b, input int a, input int p, input int r, input int rn);
        probe_t t;
        t.cyc = c; t.busy = b; t.add = a; t.pu = p; t.row = r; t.rnd = rn;
        probe_q.push_back(t);
    endtask

    task automatic push_ev(input int kind, input int c, input int rn, input int r);
        ev_t t;
        t.kind = kind; t.cyc = c; t.rnd = rn; t.row = r;
        ev_q.push_back(t);
    endtask

    // Acts at the end of each 12-cycle round after a 24-cycle pre-fill; finish one cycle after the last act.
    task automatic push_pass(input int s, input int d0, input int d1);
        push_ev(0, s + 36 + d0,      1, 3);
        push_ev(0, s + 48 + d0 + d1, 2, 4);
        push_ev(0, s + 60 + d0 + d1, 3, 5);
        push_ev(0, s + 72 + d0 + d1, 3, 5);
        push_ev(1, s + 73 + d0 + d1, 0, 0);
    endtask

    task automatic wait_cyc(input int n);
        while (cyc < n) begin
            @(posedge clk);
            #1;
        end
    endtask

    always @(negedge clk) begin
        if (act && map_finish) chk("act_fin_overlap", 1, 0);
        if (act || map_finish) begin
            if (ev_q.size() == 0) begin
                chk(act ? "unexpected_act" : "unexpected_finish", 1, 0);
            end else begin
                mon_e = ev_q.pop_front();
                chk("ev_kind", act ? 0 : 1, mon_e.kind);
                chk("ev_cycle", cyc, mon_e.cyc);
                chk("ev_round", int'(cur_round), mon_e.rnd);
                chk("ev_row", int'(cur_row_no), mon_e.row);
            end
        end
        while (probe_q.size() > 0 && probe_q[0].cyc <= cyc) begin
            mon_p = probe_q.pop_front();
            if (mon_p.cyc < cyc) begin
                chk("probe_missed", cyc, mon_p.cyc);
            end else begin
                chk("busy", int'(busy), mon_p.busy);
                chk("cur_pu_add", int'(cur_pu_add), mon_p.add);
                chk("cur_pu_no", int'(cur_pu_no), mon_p.pu);
                chk("cur_row_no", int'(cur_row_no), mon_p.row);
                chk("cur_round", int'(cur_round), mon_p.rnd);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, expected completion (cycle %0d)", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        int s;
        nrst = 1'b1;
        start = 1'b0;
        stall = 1'b0;
        pu_ready = '1;
`ifdef IMG2COL_MAP_ABORT_EN
        abort = 1'b0;
`endif
        push_probe(1, 0, 0, 0, 0, 0);
        #2 nrst = 1'b0;
        wait_cyc(2);
        nrst = 1'b1;

        // clean pass
        wait_cyc(3);
        start = 1'b1;
        s = cyc + 1;
        push_probe(s,      1, 0, 0, 0, 0);
        push_probe(s + 23, 1, 2, 3, 1, 0);
        push_probe(s + 24, 1, 0, 0, 2, 0);
        push_pass(s, 0, 0);
        wait_cyc(s);
        start = 1'b0;
        wait_cyc(s + 76);

        // PU 2 withholds ready for 7 cycles in round 1
        start = 1'b1;
        s = cyc + 1;
        push_probe(s + 44, 1, 2, 2, 3, 1);
        push_probe(s + 51, 1, 2, 2, 3, 1);
        push_probe(s + 52, 1, 0, 3, 3, 1);
        push_pass(s, 0, 7);
        wait_cyc(s);
        start = 1'b0;
        wait_cyc(s + 44);
        pu_ready[2] = 1'b0;
        wait_cyc(s + 51);
        pu_ready[2] = 1'b1;
        wait_cyc(s + 83);

        // stall in IDLE (ignored), 5 cycles in BUFFER, 3 cycles in WORK with ready high
        start = 1'b1;
        stall = 1'b1;
        s = cyc + 1;
        push_probe(s,      1, 0, 0, 0, 0);
        push_probe(s + 4,  1, 1, 1, 0, 0);
        push_probe(s + 9,  1, 1, 1, 0, 0);
        push_probe(s + 10, 1, 2, 1, 0, 0);
        push_probe(s + 29, 1, 0, 0, 2, 0);
        push_probe(s + 31, 1, 2, 0, 2, 0);
        push_probe(s + 34, 1, 2, 0, 2, 0);
        push_probe(s + 35, 1, 0, 1, 2, 0);
        push_pass(s, 8, 0);
        wait_cyc(s);
        start = 1'b0;
        stall = 1'b0;
        wait_cyc(s + 4);
        stall = 1'b1;
        wait_cyc(s + 9);
        stall = 1'b0;
        wait_cyc(s + 31);
        stall = 1'b1;
        wait_cyc(s + 34);
        stall = 1'b0;
        wait_cyc(s + 84);

        // asynchronous reset during round 2
        start = 1'b1;
        s = cyc + 1;
        push_ev(0, s + 36, 1, 3);
        push_ev(0, s + 48, 2, 4);
        push_probe(s + 48, 1, 0, 0, 4, 2);
        push_probe(s + 50, 0, 0, 0, 0, 0);
        push_probe(s + 51, 0, 0, 0, 0, 0);
        wait_cyc(s);
        start = 1'b0;
        wait_cyc(s + 50);
        nrst = 1'b0;
        wait_cyc(s + 52);
        nrst = 1'b1;
        wait_cyc(s + 82);

        // start held high: second pass begins one cycle after map_finish
        start = 1'b1;
        s = cyc + 1;
        push_probe(s + 72, 0, 0, 0, 5, 3);
        push_probe(s + 73, 0, 0, 0, 0, 0);
        push_probe(s + 74, 1, 0, 0, 0, 0);
        push_pass(s, 0, 0);
        push_pass(s + 74, 0, 0);
        wait_cyc(s + 74);
        start = 1'b0;
        wait_cyc(s + 74 + 78);

`ifdef IMG2COL_MAP_ABORT_EN
        start = 1'b1;
        s = cyc + 1;
        push_ev(0, s + 36, 1, 3);
        push_probe(s + 38, 1, 2, 0, 3, 1);
        push_probe(s + 39, 0, 0, 0, 0, 0);
        push_probe(s + 45, 0, 0, 0, 0, 0);
        wait_cyc(s);
        start = 1'b0;
        wait_cyc(s + 38);
        abort = 1'b1;
        wait_cyc(s + 39);
        abort = 1'b0;
        wait_cyc(s + 80);
`endif

        wait_cyc(cyc + 3);
        chk("ev_q_drained", ev_q.size(), 0);
        chk("probe_q_drained", probe_q.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/img2col_map_ctrl.md
Name: img2col_map_ctrl

Overview:
- Parametrised mapping controller for the img2col front end.
- Sequences the K-row pre-fill (buffering) of a bank of NUM_PU processing units, then streams one new image row per round.
- Uses a per-PU ready handshake, a global stall, and explicit round-advance and finish pulses.
- Drives the address, PU-select and row-select inputs of the img2col row buffers and PU array.

Parameters:
NUM_PU, 28, number of processing units (columns mapped per row)
KSIZE, 5, kernel height/width; words loaded per PU per row
IMG_ROWS, 32, input image rows; NUM_ROUNDS = IMG_ROWS-KSIZE+1 (localparam)
CW, 6, counter width; elaboration error if 2**CW <= max(NUM_PU, KSIZE, IMG_ROWS)

Ports:
clk  input  1  clock, all state changes on rising edge
nrst  input  1  asynchronous active-low reset
start  input  1  begin a mapping pass; sampled only in IDLE
stall  input  1  freeze all counters and state while high (BUFFER/WORK only)
pu_ready  input  NUM_PU  per-PU "accepted last word" flag, used in WORK
cur_pu_add  output  CW  word index within current PU, 0..KSIZE-1
cur_pu_no  output  CW  current PU index, 0..NUM_PU-1
cur_row_no  output  CW  image row being fetched, 0..IMG_ROWS-1
cur_round  output  CW  current output round, 0..NUM_ROUNDS-1
busy  output  1  high in BUFFER and WORK
act  output  1  one-cycle pulse when a round completes
map_finish  output  1  one-cycle pulse in FINISH

Behaviour:
- Reset (async, nrst low): state IDLE; all counters 0; busy, act and map_finish 0. Reset mid-pass aborts immediately, with no finish pulse.
- Outputs are registered. Counters update only on non-stalled cycles.
- IDLE:
  - Counters held at 0.
  - start=1 → BUFFER on the next edge.
- BUFFER (pre-fill rows 0..KSIZE-2):
  - Each cycle cur_pu_add increments.
  - At cur_pu_add=KSIZE-1: cur_pu_add→0 and cur_pu_no increments.
  - At cur_pu_no=NUM_PU-1 with cur_pu_add=KSIZE-1: cur_pu_no→0 and cur_row_no increments.
  - When this wrap takes cur_row_no to KSIZE-1 → WORK, with cur_round=0.
  - Duration: (KSIZE-1)*NUM_PU*KSIZE non-stalled cycles. pu_ready is ignored.
- WORK:
  - cur_pu_add increments to KSIZE-1, then waits.
  - Leaves the last word only when pu_ready[cur_pu_no]=1; it then goes to 0 and cur_pu_no advances.
  - If pu_ready is low, the controller holds at cur_pu_add=KSIZE-1 indefinitely.
  - When the last PU (NUM_PU-1) is accepted:
    - cur_pu_no→0 and act=1 for one cycle.
    - If cur_round < NUM_ROUNDS-1: cur_round and cur_row_no increment.
    - Otherwise: counters hold and state → FINISH.
- FINISH: map_finish=1 for exactly one cycle → IDLE. Counters clear on entering IDLE.
- Simultaneous events:
  - stall has priority over pu_ready. A pu_ready seen during stall is not consumed; it must still be high on the first non-stalled cycle.
  - start outside IDLE is ignored.
  - stall in IDLE/FINISH has no effect.
- Arithmetic: all counters are unsigned CW bits. No counter ever exceeds its stated range, and no wrap beyond it is permitted.
- act and map_finish are never high in the same cycle, except act on the final round, which precedes map_finish by exactly one cycle.

Optional Feature:
- Macro IMG2COL_MAP_ABORT_EN.
- Defined:
  - Adds input port abort (1 bit).
  - abort=1 in BUFFER or WORK → IDLE on the next edge, counters cleared, no act or map_finish.
  - abort has priority over stall and pu_ready; it is ignored in IDLE/FINISH.
- Undefined: the port is absent and behaviour is as above.

Test Plan:
- Config NUM_PU=4, KSIZE=3, IMG_ROWS=6, pu_ready all 1, start pulsed → busy next cycle; WORK entered after 24 cycles; act pulses every 12 cycles, 4 times; map_finish one cycle after 4th act; cur_row_no reaches 5.
- Same config, pu_ready[2]=0 for 7 cycles in round 1 → cur_pu_no=2, cur_pu_add=2 held 7 cycles; round completes 7 cycles late; act count still 4.
- stall high 5 cycles mid-BUFFER at pu_no=1, pu_add=1 → all outputs frozen 5 cycles; WORK entry delayed by exactly 5.
- nrst low during WORK round 2 → all outputs 0 asynchronously; no map_finish; new start runs a full pass correctly.
- start held high through whole pass → exactly one pass, then a second pass starts one cycle after map_finish.
- IMG2COL_MAP_ABORT_EN defined, abort in WORK round 1 → IDLE next cycle, counters 0, no map_finish.
